// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - funct3 encodings for loads and stores
//   - responder state enum (CLEAR sweep, READY for requests)
//   - word offsets of the MMIO registers inside the top four words
//     of the address space (used only when DMEM_MMIO_EN is defined)
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_e;

  // Offsets are addr[3:2] within the MMIO window.
  localparam logic [1:0] MMIO_CYCLE_OFF   = 2'd0;
  localparam logic [1:0] MMIO_STORES_OFF  = 2'd1;
  localparam logic [1:0] MMIO_SCRATCH_OFF = 2'd2;
  localparam logic [1:0] MMIO_ERR_OFF     = 2'd3;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
// Purely combinational lane steering for one 32-bit memory word.
// Ports:
//   func3       in   access type (shared encoding for loads and stores)
//   addr_lo     in   byte offset within the word (addr[1:0])
//   wr_data     in   raw store data from the pipeline
//   rd_word     in   word currently held at the addressed location
//   st_be       out  byte enables for a store (zero if misaligned/reserved)
//   st_data     out  store data replicated into every candidate lane
//   st_misalign out  store violates its natural alignment
//   ld_data     out  extracted and sign/zero-extended load data
//   ld_misalign out  load violates its natural alignment
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  output logic        st_misalign,
  output logic [31:0] ld_data,
  output logic        ld_misalign
);

  logic [15:0] lane;

  // Replicating the data lets the byte enables alone pick the target lane.
  always_comb begin
    st_be       = 4'b0000;
    st_data     = wr_data;
    st_misalign = 1'b0;
    case (func3)
      F3_B: begin
        st_be   = 4'b0001 << addr_lo;
        st_data = {4{wr_data[7:0]}};
      end
      F3_H: begin
        st_be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_data     = {2{wr_data[15:0]}};
        st_misalign = addr_lo[0];
      end
      F3_W: begin
        st_be       = 4'b1111;
        st_misalign = (addr_lo != 2'b00);
      end
      default: st_be = 4'b0000;
    endcase
    if (st_misalign) st_be = 4'b0000;
  end

  // The addressed byte/half is shifted down to bit 0 before extension.
  always_comb begin
    lane        = 16'(rd_word >> {addr_lo, 3'b000});
    ld_data     = '0;
    ld_misalign = 1'b0;
    case (func3)
      F3_B:  ld_data = {{24{lane[7]}}, lane[7:0]};
      F3_BU: ld_data = {24'b0, lane[7:0]};
      F3_H: begin
        ld_misalign = addr_lo[0];
        ld_data     = {{16{lane[15]}}, lane};
      end
      F3_HU: begin
        ld_misalign = addr_lo[0];
        ld_data     = {16'b0, lane};
      end
      F3_W: begin
        ld_misalign = (addr_lo != 2'b00);
        ld_data     = rd_word;
      end
      default: ld_data = '0;
    endcase
    if (ld_misalign) ld_data = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Target end of the MEM-stage load/store interface. Zero-fills the word
// array after reset (busy high), then serves one load or store per cycle.
// Loads are combinational; stores commit on the edge ending the request.
// Misaligned accesses are suppressed and recorded in a sticky error flag.
// Optional feature macro: DMEM_MMIO_EN maps the top four words onto a
// cycle counter, store counter, scratch register and error-clear register.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   MemRead       load request this cycle
//   MemWrite      store request this cycle (wins over MemRead)
//   addr          byte address
//   wr_data       store data (low bytes for SB/SH)
//   func3         access type
//   rd_data       extended load data, combinational
//   busy          clear sweep in progress
//   misalign_err  sticky misaligned-access flag
//   err_addr      address of the first misaligned access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  misalign_err,
  output logic [DM_ADDRESS-1:0] err_addr
);

  localparam int IDX_W = DM_ADDRESS - 2;
`ifdef DMEM_MMIO_EN
  localparam int RAM_WORDS = (1 << IDX_W) - 4;
`else
  localparam int RAM_WORDS = (1 << IDX_W);
`endif
  localparam logic [IDX_W-1:0] RAM_LAST = IDX_W'(RAM_WORDS - 1);

  dmem_state_e           state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  mis_q, mis_d;
  logic [DM_ADDRESS-1:0] err_q, err_d;

  logic [31:0]      mem_q [RAM_WORDS];
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;

  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;
  logic [3:0]       st_be;
  logic [31:0]      st_data, ld_data;
  logic             st_misalign, ld_misalign;

`ifdef DMEM_MMIO_EN
  logic        mmio_hit;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] stores_q, stores_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] mmio_word;
  logic [31:0] be_mask;
`endif

  assign word_idx     = addr[DM_ADDRESS-1:2];
  assign busy         = (state_q == CLEAR);
  assign misalign_err = mis_q;
  assign err_addr     = err_q;

`ifdef DMEM_MMIO_EN
  assign mmio_hit = &word_idx[IDX_W-1:2];
  assign be_mask  = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};

  always_comb begin
    mmio_word = '0;
    case (addr[3:2])
      MMIO_CYCLE_OFF:   mmio_word = cycle_q;
      MMIO_STORES_OFF:  mmio_word = stores_q;
      MMIO_SCRATCH_OFF: mmio_word = scratch_q;
      MMIO_ERR_OFF:     mmio_word = {31'b0, mis_q};
      default:          mmio_word = '0;
    endcase
  end

  assign rd_word = mmio_hit ? mmio_word : mem_q[word_idx];
`else
  assign rd_word = mem_q[word_idx];
`endif

  dmem_lane_align u_lane (
    .func3       (func3),
    .addr_lo     (addr[1:0]),
    .wr_data     (wr_data[31:0]),
    .rd_word     (rd_word),
    .st_be       (st_be),
    .st_data     (st_data),
    .st_misalign (st_misalign),
    .ld_data     (ld_data),
    .ld_misalign (ld_misalign)
  );

  // Next state, array write port and load result. A store always takes
  // precedence over a simultaneous load, which then returns zero.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mis_d     = mis_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_wdata = st_data;
    mem_be    = st_be;
    rd_data   = '0;
`ifdef DMEM_MMIO_EN
    cycle_d   = cycle_q;
    stores_d  = stores_q;
    scratch_d = scratch_q;
`endif
    case (state_q)
      CLEAR: begin
        ptr_d     = ptr_q + 1'b1;
        mem_we    = (ptr_q <= RAM_LAST);
        mem_idx   = ptr_q;
        mem_wdata = '0;
        mem_be    = 4'b1111;
        if (ptr_q == '1) state_d = READY;
      end
      READY: begin
`ifdef DMEM_MMIO_EN
        cycle_d = cycle_q + 32'd1;
`endif
        if (MemWrite) begin
          if (st_misalign) begin
            mis_d = 1'b1;
            if (!mis_q) err_d = addr;
          end else if (st_be != 4'b0000) begin
`ifdef DMEM_MMIO_EN
            stores_d = stores_q + 32'd1;
            if (mmio_hit) begin
              if (addr[3:2] == MMIO_SCRATCH_OFF) begin
                scratch_d = (scratch_q & ~be_mask) | (st_data & be_mask);
              end else if (addr[3:2] == MMIO_ERR_OFF) begin
                mis_d = 1'b0;
                err_d = '0;
              end
            end else begin
              mem_we = 1'b1;
            end
`else
            mem_we = 1'b1;
`endif
          end
        end else if (MemRead) begin
          if (ld_misalign) begin
            mis_d = 1'b1;
            if (!mis_q) err_d = addr;
          end else begin
            rd_data = DATA_W'(ld_data);
          end
        end
      end
      default: state_d = CLEAR;
    endcase
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= '0;
`ifdef DMEM_MMIO_EN
      cycle_q   <= '0;
      stores_q  <= '0;
      scratch_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
`ifdef DMEM_MMIO_EN
      cycle_q   <= cycle_d;
      stores_q  <= stores_d;
      scratch_q <= scratch_d;
`endif
    end
  end

  // Byte-lane write port; the array has no reset, the sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed table-driven bench for dmem_responder. Each vector is one
// request cycle: rd_data is sampled mid-cycle, the sticky error state
// just after the edge that ends the cycle. Hand sequences cover the
// reset/clear sweep and, when DMEM_MMIO_EN is defined, the MMIO window.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [2:0]  func3;
  logic [31:0] rd_data;
  logic        busy;
  logic        misalign_err;
  logic [8:0]  err_addr;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic [8:0]  exp_err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .addr         (addr),
    .wr_data      (wr_data),
    .func3        (func3),
    .rd_data      (rd_data),
    .busy         (busy),
    .misalign_err (misalign_err),
    .err_addr     (err_addr)
  );

  // Compares one value and records the outcome.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [8:0] a, input logic [31:0] wd);
    MemRead  = rd;
    MemWrite = wr;
    func3    = f3;
    addr     = a;
    wr_data  = wd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, F3_W, 9'h000, 32'h0);
  endtask

  function automatic void addVec(input string name, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd,
                                 input logic [31:0] exp_rd, input logic exp_mis, input logic [8:0] exp_err);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_mis = exp_mis; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  // One request cycle, entered and left at posedge+1.
  task automatic runVector(input vec_t v);
    applyStimulus(v.rd, v.wr, v.f3, v.a, v.wd);
    #3;
    checkOutput({v.name, " rd_data"}, rd_data, v.exp_rd);
    @(posedge clk);
    #1;
    checkOutput({v.name, " misalign_err"}, {31'b0, misalign_err}, {31'b0, v.exp_mis});
    checkOutput({v.name, " err_addr"}, {23'b0, err_addr}, {23'b0, v.exp_err});
  endtask

  task automatic doReset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Counts cycles with busy high, bounded; optionally issues requests.
  task automatic sweep(input bit with_requests);
    int cnt;
    cnt = 0;
    while (busy && cnt < 1000) begin
      if (with_requests) begin
        if (cnt < 64) applyStimulus(1'b1, 1'b0, F3_W, 9'h040, 32'h0);
        else          applyStimulus(1'b0, 1'b1, F3_W, 9'h044, 32'h12345678);
      end
      #3;
      if (with_requests && cnt == 10) checkOutput("LW 0x040 during sweep", rd_data, 32'h0);
      @(posedge clk);
      #1;
      cnt++;
    end
    idle();
    checkOutput("busy cycle count", cnt, 128);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    idle();
    doReset();
    checkOutput("reset busy", {31'b0, busy}, 32'd1);
    checkOutput("reset misalign_err", {31'b0, misalign_err}, 32'd0);
    checkOutput("reset err_addr", {23'b0, err_addr}, 32'd0);
    checkOutput("reset rd_data", rd_data, 32'd0);
    sweep(1'b0);

    // Leave stale data in word 0x10, then reset mid-operation.
    addVec("SW 0x040 pre", 1'b0, 1'b1, F3_W, 9'h040, 32'hDEADBEEF, 32'h0, 1'b0, 9'h000);
    addVec("LW 0x040 pre", 1'b1, 1'b0, F3_W, 9'h040, 32'h0, 32'hDEADBEEF, 1'b0, 9'h000);
    foreach (vecs[i]) runVector(vecs[i]);
    vecs.delete();

    doReset();
    checkOutput("second reset busy", {31'b0, busy}, 32'd1);
    sweep(1'b1);

    addVec("LW 0x040 cleared", 1'b1, 1'b0, F3_W,  9'h040, 32'h0, 32'h00000000, 1'b0, 9'h000);
    addVec("LW 0x044 ignored", 1'b1, 1'b0, F3_W,  9'h044, 32'h0, 32'h00000000, 1'b0, 9'h000);
    addVec("SW 0x010",         1'b0, 1'b1, F3_W,  9'h010, 32'h80FF7F01, 32'h0, 1'b0, 9'h000);
    addVec("LB 0x013",         1'b1, 1'b0, F3_B,  9'h013, 32'h0, 32'hFFFFFF80, 1'b0, 9'h000);
    addVec("LBU 0x013",        1'b1, 1'b0, F3_BU, 9'h013, 32'h0, 32'h00000080, 1'b0, 9'h000);
    addVec("LH 0x012",         1'b1, 1'b0, F3_H,  9'h012, 32'h0, 32'hFFFF80FF, 1'b0, 9'h000);
    addVec("LHU 0x012",        1'b1, 1'b0, F3_HU, 9'h012, 32'h0, 32'h000080FF, 1'b0, 9'h000);
    addVec("LH 0x010",         1'b1, 1'b0, F3_H,  9'h010, 32'h0, 32'h00007F01, 1'b0, 9'h000);
    addVec("LB 0x011",         1'b1, 1'b0, F3_B,  9'h011, 32'h0, 32'h0000007F, 1'b0, 9'h000);
    addVec("LB 0x012",         1'b1, 1'b0, F3_B,  9'h012, 32'h0, 32'hFFFFFFFF, 1'b0, 9'h000);
    addVec("LW 0x010",         1'b1, 1'b0, F3_W,  9'h010, 32'h0, 32'h80FF7F01, 1'b0, 9'h000);
    addVec("LW reserved f3",   1'b1, 1'b0, 3'b011, 9'h010, 32'h0, 32'h00000000, 1'b0, 9'h000);
    addVec("SW 0x020",         1'b0, 1'b1, F3_W,  9'h020, 32'h11223344, 32'h0, 1'b0, 9'h000);
    addVec("SB 0x021",         1'b0, 1'b1, F3_B,  9'h021, 32'hFFFFFFAB, 32'h0, 1'b0, 9'h000);
    addVec("LW 0x020 after SB", 1'b1, 1'b0, F3_W, 9'h020, 32'h0, 32'h1122AB44, 1'b0, 9'h000);
    addVec("SH 0x022",         1'b0, 1'b1, F3_H,  9'h022, 32'hABCDBEEF, 32'h0, 1'b0, 9'h000);
    addVec("LW 0x020 after SH", 1'b1, 1'b0, F3_W, 9'h020, 32'h0, 32'hBEEFAB44, 1'b0, 9'h000);
    addVec("LHU 0x022",        1'b1, 1'b0, F3_HU, 9'h022, 32'h0, 32'h0000BEEF, 1'b0, 9'h000);
    addVec("RW both SW 0x050", 1'b1, 1'b1, F3_W,  9'h050, 32'h00000007, 32'h0, 1'b0, 9'h000);
    addVec("LW 0x050",         1'b1, 1'b0, F3_W,  9'h050, 32'h0, 32'h00000007, 1'b0, 9'h000);
    addVec("SW 0x030",         1'b0, 1'b1, F3_W,  9'h030, 32'hCAFEF00D, 32'h0, 1'b0, 9'h000);
    addVec("SH 0x031 misalign", 1'b0, 1'b1, F3_H, 9'h031, 32'h00005555, 32'h0, 1'b1, 9'h031);
    addVec("LW 0x030 unchanged", 1'b1, 1'b0, F3_W, 9'h030, 32'h0, 32'hCAFEF00D, 1'b1, 9'h031);
    addVec("LW 0x033 misalign", 1'b1, 1'b0, F3_W, 9'h033, 32'h0, 32'h00000000, 1'b1, 9'h031);
    addVec("LH 0x035 misalign", 1'b1, 1'b0, F3_H, 9'h035, 32'h0, 32'h00000000, 1'b1, 9'h031);
`ifdef DMEM_MMIO_EN
    addVec("SW 0x1FC clear",   1'b0, 1'b1, F3_W,  9'h1FC, 32'h5A5AA5A5, 32'h0, 1'b0, 9'h000);
    addVec("LW 0x1FC",         1'b1, 1'b0, F3_W,  9'h1FC, 32'h0, 32'h00000000, 1'b0, 9'h000);
`else
    addVec("SW 0x1FC top",     1'b0, 1'b1, F3_W,  9'h1FC, 32'h5A5AA5A5, 32'h0, 1'b1, 9'h031);
    addVec("LW 0x1FC top",     1'b1, 1'b0, F3_W,  9'h1FC, 32'h0, 32'h5A5AA5A5, 1'b1, 9'h031);
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      runVector(v);
    end
    vecs.delete();

`ifdef DMEM_MMIO_EN
    doReset();
    sweep(1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    addVec("LW cycle counter", 1'b1, 1'b0, F3_W, 9'h1F0, 32'h0, 32'd10, 1'b0, 9'h000);
    addVec("SW 0x000",  1'b0, 1'b1, F3_W, 9'h000, 32'h1, 32'h0, 1'b0, 9'h000);
    addVec("SW 0x004",  1'b0, 1'b1, F3_W, 9'h004, 32'h2, 32'h0, 1'b0, 9'h000);
    addVec("SW scratch", 1'b0, 1'b1, F3_W, 9'h1F8, 32'h11223344, 32'h0, 1'b0, 9'h000);
    addVec("LW store counter", 1'b1, 1'b0, F3_W, 9'h1F4, 32'h0, 32'd3, 1'b0, 9'h000);
    addVec("SB scratch", 1'b0, 1'b1, F3_B, 9'h1FA, 32'h000000AA, 32'h0, 1'b0, 9'h000);
    addVec("LW scratch", 1'b1, 1'b0, F3_W, 9'h1F8, 32'h0, 32'h11AA3344, 1'b0, 9'h000);
    addVec("SW cycle ro", 1'b0, 1'b1, F3_W, 9'h1F0, 32'hFFFFFFFF, 32'h0, 1'b0, 9'h000);
    addVec("LW store counter 5", 1'b1, 1'b0, F3_W, 9'h1F4, 32'h0, 32'd5, 1'b0, 9'h000);
    addVec("LH 0x001 misalign", 1'b1, 1'b0, F3_H, 9'h001, 32'h0, 32'h0, 1'b1, 9'h001);
    addVec("LW err reg", 1'b1, 1'b0, F3_W, 9'h1FC, 32'h0, 32'h1, 1'b1, 9'h001);
    addVec("SW err clear", 1'b0, 1'b1, F3_W, 9'h1FC, 32'h0, 32'h0, 1'b0, 9'h000);
    addVec("LW err reg cleared", 1'b1, 1'b0, F3_W, 9'h1FC, 32'h0, 32'h0, 1'b0, 9'h000);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      runVector(v);
    end
    vecs.delete();
`endif

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
